// File: rtl/grid_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// grid_sweep_scheduler
//
// Purpose:
//   Loads a WIDTH x DEPTH occupancy grid (1 = paper, 0 = empty) row by row
//   over a valid/ready stream, presents it to an external single-sweep
//   combinational removal unit, and commits one sweep per clock until a sweep
//   removes nothing or MAX_ITER productive sweeps have been committed. The
//   accumulated result is then offered on a valid/ready result port.
//
// Optional feature (macro GRID_POPCOUNT_EN):
//   Adds res_remaining, the population count of grid_q captured on entry to
//   DONE. With the macro undefined the port and its logic are absent.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   abort         synchronous abort back to IDLE (clears frame and results)
//   row_valid     row_data valid
//   row_ready     block accepts a row this cycle (IDLE, LOAD)
//   row_data      one grid row, bit j = column j
//   grid_q        current frame to the sweep unit, row i at [i*WIDTH +: WIDTH]
//   grid_next     sweep unit result frame (same packing)
//   sweep_removed cells removed by the sweep unit for grid_q
//   sweep_any     sweep unit removed at least one cell
//   busy          state is LOAD or SWEEP
//   res_valid     result available (DONE)
//   res_ready     result consumer ready
//   res_total     total cells removed over all sweeps
//   res_first     cells removed by the first sweep
//   res_iters     number of productive sweeps committed
//   res_capped    stopped because res_iters reached MAX_ITER
//   res_remaining (GRID_POPCOUNT_EN) occupied cells left in the final frame
// -----------------------------------------------------------------------------
module grid_sweep_scheduler #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int MAX_ITER = 255,
  parameter int CW       = $clog2(WIDTH*DEPTH+1),
  parameter int IW       = $clog2(MAX_ITER+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   abort,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [WIDTH-1:0]       row_data,
  output logic [WIDTH*DEPTH-1:0] grid_q,
  input  logic [WIDTH*DEPTH-1:0] grid_next,
  input  logic [CW-1:0]          sweep_removed,
  input  logic                   sweep_any,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CW-1:0]          res_total,
  output logic [CW-1:0]          res_first,
  output logic [IW-1:0]          res_iters,
  output logic                   res_capped
`ifdef GRID_POPCOUNT_EN
  ,
  output logic [CW-1:0]          res_remaining
`endif
);

  localparam int N  = WIDTH * DEPTH;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(DEPTH - 1);
  localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [N-1:0]    r_grid;
  logic [RW-1:0]   r_row_idx;
  logic [CW-1:0]   r_total;
  logic [CW-1:0]   r_first;
  logic [IW-1:0]   r_iters;
  logic            r_capped;

  logic            w_row_we;
  logic [RW-1:0]   w_row_sel;
  logic            w_last_row;
  logic            w_commit;
  logic [IW-1:0]   w_iters_inc;
  logic            w_cap_hit;

`ifdef GRID_POPCOUNT_EN
  logic [CW-1:0]   r_remaining;
  logic [N-1:0]    w_grid_d;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] g);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(g[i]);
    end
    return c;
  endfunction
`endif

  // Row write strobe and target row. In IDLE the incoming row is always
  // row 0, whatever the index register holds.
  assign w_row_we    = row_valid && row_ready;
  assign w_row_sel   = (r_state == S_IDLE) ? '0 : r_row_idx;
  assign w_last_row  = ((r_state == S_IDLE) && (DEPTH == 1)) ||
                       ((r_state == S_LOAD) && (r_row_idx == LAST_ROW));

  // r_iters < MAX_ITER whenever SWEEP is active, so the increment fits in IW.
  assign w_commit    = (r_state == S_SWEEP) && sweep_any;
  assign w_iters_inc = r_iters + IW'(1);
  assign w_cap_hit   = (w_iters_inc == ITER_CAP);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    row_ready    = 1'b0;
    busy         = 1'b0;
    res_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        row_ready = 1'b1;
        if (row_valid) begin
          w_state_next = (DEPTH == 1) ? S_SWEEP : S_LOAD;
        end
      end
      S_LOAD: begin
        row_ready = 1'b1;
        busy      = 1'b1;
        if (row_valid && (r_row_idx == LAST_ROW)) begin
          w_state_next = S_SWEEP;
        end
      end
      S_SWEEP: begin
        busy = 1'b1;
        if (!sweep_any || w_cap_hit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Abort wins over any row or result handshake in the same cycle.
    if (abort) begin
      w_state_next = S_IDLE;
    end
  end

`ifdef GRID_POPCOUNT_EN
  // Frame that grid_q will hold after this edge; used to capture the final
  // occupancy on the edge that enters DONE.
  assign w_grid_d = w_commit ? grid_next : r_grid;
`endif

  // ---------------------------------------------------------------------------
  // Frame, row index and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the grid frame is a plain register (not a RAM), so it is cleared by
  // reset and abort along with the counters; grid_q must read 0 after either.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grid      <= '0;
      r_row_idx   <= '0;
      r_total     <= '0;
      r_first     <= '0;
      r_iters     <= '0;
      r_capped    <= 1'b0;
`ifdef GRID_POPCOUNT_EN
      r_remaining <= '0;
`endif
    end else if (abort) begin
      r_grid      <= '0;
      r_row_idx   <= '0;
      r_total     <= '0;
      r_first     <= '0;
      r_iters     <= '0;
      r_capped    <= 1'b0;
`ifdef GRID_POPCOUNT_EN
      r_remaining <= '0;
`endif
    end else begin
      if (w_row_we) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_row_sel == RW'(i)) begin
            r_grid[i*WIDTH +: WIDTH] <= row_data;
          end
        end
        r_row_idx <= w_last_row ? '0 : (w_row_sel + RW'(1));
      end

      // A new job starts with the first row; results of the previous job are
      // held until then so the consumer may re-read them from IDLE.
      if ((r_state == S_IDLE) && row_valid) begin
        r_total     <= '0;
        r_first     <= '0;
        r_iters     <= '0;
        r_capped    <= 1'b0;
`ifdef GRID_POPCOUNT_EN
        r_remaining <= '0;
`endif
      end

      if (w_commit) begin
        r_grid   <= grid_next;
        r_total  <= r_total + sweep_removed;
        r_iters  <= w_iters_inc;
        if (r_iters == '0) begin
          r_first <= sweep_removed;
        end
        if (w_cap_hit) begin
          r_capped <= 1'b1;
        end
      end

`ifdef GRID_POPCOUNT_EN
      if ((r_state == S_SWEEP) && (!sweep_any || w_cap_hit)) begin
        r_remaining <= popcount(w_grid_d);
      end
`endif
    end
  end

  assign grid_q     = r_grid;
  assign res_total  = r_total;
  assign res_first  = r_first;
  assign res_iters  = r_iters;
  assign res_capped = r_capped;
`ifdef GRID_POPCOUNT_EN
  assign res_remaining = r_remaining;
`endif

endmodule

// File: doc/grid_sweep_scheduler.md
Name: grid_sweep_scheduler

Overview:
- Sequences repeated removal sweeps over a WIDTH x DEPTH occupancy grid (1 = paper, 0 = empty).
- Loads the grid row by row over a valid/ready stream into an internal frame register and presents it to an external single-sweep combinational removal unit.
- Commits one sweep per clock until a sweep removes nothing or an iteration cap is hit.
- Reports the total removed, the first-sweep count and the sweep count on a valid/ready result port.

Parameters:
- WIDTH, 16, columns per row (>=1)
- DEPTH, 16, rows per grid (>=1)
- MAX_ITER, 255, maximum productive sweeps before forced stop (>=1)
- CW, $clog2(WIDTH*DEPTH+1), count width (derived; do not override)
- IW, $clog2(MAX_ITER+1), iteration counter width (derived)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- abort  in  1  synchronous abort; returns block to IDLE
- row_valid  in  1  row_data valid
- row_ready  out  1  block accepts a row this cycle
- row_data  in  WIDTH  one grid row, bit j = column j
- grid_q  out  WIDTH*DEPTH  current frame to sweep unit; row i at [i*WIDTH +: WIDTH]
- grid_next  in  WIDTH*DEPTH  sweep unit result frame (same packing)
- sweep_removed  in  CW  cells removed by sweep unit this cycle
- sweep_any  in  1  sweep unit removed >=1 cell
- busy  out  1  state is LOAD or SWEEP
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_total  out  CW  total cells removed over all sweeps
- res_first  out  CW  cells removed by first sweep
- res_iters  out  IW  number of productive sweeps committed
- res_capped  out  1  stopped because res_iters reached MAX_ITER

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grid_q, row index, res_total, res_first, res_iters and res_capped =0; res_valid=0.
- States: IDLE, LOAD, SWEEP, DONE.
- IDLE: row_ready=1. On a row handshake: write row 0; clear res_total, res_first, res_iters and res_capped; row index=1. Next state is LOAD, or SWEEP if DEPTH==1. res_* hold their previous values until this handshake.
- LOAD: row_ready=1. Each handshake writes row[row index] and increments the index. The handshake on row DEPTH-1 moves to SWEEP. Cycles with row_valid=0 hold state.
- SWEEP: row_ready=0. One evaluation per cycle.
  - If sweep_any=1: grid_q<=grid_next; res_total+=sweep_removed; if res_iters==0 then res_first<=sweep_removed; res_iters++. If res_iters+1==MAX_ITER: res_capped<=1, go DONE.
  - If sweep_any=0: grid_q unchanged, go DONE.
- DONE: res_valid=1; all res_* and grid_q stable. row_valid is ignored (row_ready=0). A res_valid&&res_ready handshake moves to IDLE; res_valid drops the next cycle.
- Latency: last row accepted at cycle T; first sweep at T+1. If N productive sweeps occur and no cap is hit, res_valid rises at T+N+2.
- Arithmetic: res_total cannot exceed WIDTH*DEPTH because each cell is removed at most once, so no saturation logic. Bench checks res_total <= WIDTH*DEPTH.
- abort=1 in any state: next state IDLE; grid_q, index and all res_* cleared; res_valid=0. abort has priority over row and result handshakes in the same cycle.
- sweep_removed and grid_next are sampled only in SWEEP. Their values in other states have no effect.

Optional Feature:
- Macro GRID_POPCOUNT_EN.
- Defined: adds output res_remaining (CW) = population count of grid_q, registered on entry to DONE, held stable while res_valid=1, cleared with the other res_* outputs.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=DEPTH=4, all-ones grid, bench models the sweep unit (remove occupied cells with <4 occupied neighbours) -> res_total=4, res_first=4, res_iters=1, res_capped=0; res_valid rises at T+3 after the last row.
- WIDTH=DEPTH=4, all-zero grid -> res_total=0, res_first=0, res_iters=0, res_valid at T+2; with GRID_POPCOUNT_EN, res_remaining=0.
- MAX_ITER=1, all-ones 4x4 -> DONE after the first productive sweep, res_capped=1, res_iters=1, res_total=4; with GRID_POPCOUNT_EN, res_remaining=12.
- res_ready held 0 for 10 cycles in DONE with row_valid=1 -> res_valid stays 1, res_* stable, row_ready=0, no row written; res_ready=1 -> IDLE next cycle.
- abort during LOAD after 2 rows, then a full fresh all-ones 4x4 load -> IDLE after the abort; result identical to scenario 1.
- reset driven low mid-SWEEP asynchronously -> res_valid, busy, grid_q and counts read 0 before the next clk edge; state IDLE with row_ready=1.
